// File: rtl/pipe_ctrl_n.sv
// Pipeline hazard controller: per-boundary stall/flush combine plus a stall watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_n #(
    parameter  int unsigned NSTAGES       = 4,
    parameter  int unsigned STALL_TIMEOUT = 1024,
    parameter  int unsigned CNT_W         = 32,
    localparam int unsigned SEL_W         = $clog2(2 * NSTAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NSTAGES-1:0]           stall_req,
    input  logic [NSTAGES*NSTAGES-1:0]   flush_req,
    output logic [NSTAGES-1:0]           stall_o,
    output logic [NSTAGES-1:0]           flush_o,
    output logic                         wd_fire_o,
    output logic                         wd_seen_o,
    input  logic [SEL_W-1:0]             perf_sel_i,
    input  logic                         perf_clr_i,
    output logic [CNT_W-1:0]             perf_data_o
);

    localparam int unsigned WD_W = (STALL_TIMEOUT == 0) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam bit          WD_EN = (STALL_TIMEOUT != 0);

    logic [NSTAGES-1:0] stall_base;
    logic [NSTAGES-1:0] flush_base;
    logic               any_flush;
    logic [WD_W-1:0]    wd_cnt;
    logic               wd_hit;

    // A stall at stage k freezes boundary k and every older boundary.
    always_comb begin
        stall_base = '0;
        flush_base = '0;
        for (int unsigned j = 0; j < NSTAGES; j++) begin
            for (int unsigned k = 0; k < NSTAGES; k++) begin
                if (k >= j) begin
                    stall_base[j] = stall_base[j] | stall_req[k];
                end
                flush_base[j] = flush_base[j] | flush_req[k*NSTAGES + j];
            end
        end
    end

    assign any_flush = |flush_base;
    assign wd_hit    = WD_EN && !rst && stall_base[0] && !any_flush
                       && (wd_cnt == WD_W'(STALL_TIMEOUT));

    // Watchdog fire overrides everything with a full flush.
    always_comb begin
        flush_o   = flush_base;
        stall_o   = stall_base & ~flush_base;
        wd_fire_o = 1'b0;
        if (wd_hit) begin
            flush_o   = '1;
            stall_o   = '0;
            wd_fire_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !WD_EN || !stall_base[0] || any_flush || wd_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_seen_o <= 1'b0;
        end else if (wd_hit) begin
            wd_seen_o <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam int unsigned NCNT = 2 * NSTAGES;

    logic [CNT_W-1:0] perf_cnt [NCNT];
    logic [NCNT-1:0]  perf_ev;
    logic [CNT_W-1:0] perf_rd;

    assign perf_ev = {flush_o, stall_o};

    // Saturating event counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (rst || perf_clr_i) begin
                perf_cnt[i] <= '0;
            end else if (perf_ev[i] && (perf_cnt[i] != '1)) begin
                perf_cnt[i] <= perf_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        perf_rd = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (perf_sel_i == SEL_W'(i)) begin
                perf_rd = perf_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr_i) begin
            perf_data_o <= '0;
        end else begin
            perf_data_o <= perf_rd;
        end
    end
`else
    logic unused_perf;

    assign unused_perf = ^{perf_sel_i, perf_clr_i};
    assign perf_data_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Randomized and directed bench for pipe_ctrl_n against a cycle-level reference model.
module tb_pipe_ctrl_n;

    localparam int N  = 4;
    localparam int T  = 8;
    localparam int CW = 4;
    localparam int NC = 2 * N;
    localparam int SAT = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall_req;
    logic [15:0] flush_req;
    logic [2:0]  perf_sel_i;
    logic        perf_clr_i;

    logic [3:0]    stall_o, flush_o, stall0, flush0;
    logic          wd_fire_o, wd_seen_o, fire0, seen0;
    logic [CW-1:0] perf_data_o, perf0;

    always #5 clk = ~clk;

    pipe_ctrl_n #(.NSTAGES(N), .STALL_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
        .stall_o(stall_o), .flush_o(flush_o), .wd_fire_o(wd_fire_o), .wd_seen_o(wd_seen_o),
        .perf_sel_i(perf_sel_i), .perf_clr_i(perf_clr_i), .perf_data_o(perf_data_o)
    );

    pipe_ctrl_n #(.NSTAGES(N), .STALL_TIMEOUT(0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
        .stall_o(stall0), .flush_o(flush0), .wd_fire_o(fire0), .wd_seen_o(seen0),
        .perf_sel_i(perf_sel_i), .perf_clr_i(perf_clr_i), .perf_data_o(perf0)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: consecutive stalled cycles, sticky flag, counters, read register.
    int run;
    bit seen;
    int cnt [NC];
    int rd;

    bit       cur_r, cur_clr, m_fire, any_f;
    bit [3:0] m_base, b_flush, m_stall, m_flush;
    int       cur_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input logic [3:0] s, input logic [15:0] f,
                         input logic [2:0] sel, input bit clr);
        rst        = r;
        stall_req  = s;
        flush_req  = f;
        perf_sel_i = sel;
        perf_clr_i = clr;
        #1;
        for (int j = 0; j < N; j++) begin
            m_base[j]  = ((s >> j) != 0);
            b_flush[j] = 1'b0;
            for (int k = 0; k < N; k++) b_flush[j] = b_flush[j] | f[k*N + j];
        end
        any_f  = (b_flush != 0);
        m_fire = !r && m_base[0] && !any_f && (run == T);
        if (m_fire) begin
            m_flush = 4'hF;
            m_stall = 4'h0;
        end else begin
            m_flush = b_flush;
            m_stall = m_base & ~b_flush;
        end
        cur_r   = r;
        cur_clr = clr;
        cur_sel = int'(sel);
        check("stall", 32'(stall_o), 32'(m_stall));
        check("flush", 32'(flush_o), 32'(m_flush));
        check("fire", 32'(wd_fire_o), 32'(m_fire));
        check("seen", 32'(wd_seen_o), 32'(seen));
`ifdef PIPE_CTRL_PERF_EN
        check("perf", 32'(perf_data_o), 32'(rd));
`else
        check("perf_off", 32'(perf_data_o), 32'd0);
`endif
        check("t0_stall", 32'(stall0), 32'(m_base & ~b_flush));
        check("t0_flush", 32'(flush0), 32'(b_flush));
        check("t0_fire", 32'(fire0), 32'd0);
    endtask

    task automatic advance();
        if (cur_r) begin
            run  = 0;
            seen = 1'b0;
            rd   = 0;
            for (int i = 0; i < NC; i++) cnt[i] = 0;
        end else begin
            if (m_fire) begin
                run  = 0;
                seen = 1'b1;
            end else if (m_base[0] && !any_f) begin
                run++;
            end else begin
                run = 0;
            end
            if (cur_clr) begin
                rd = 0;
                for (int i = 0; i < NC; i++) cnt[i] = 0;
            end else begin
                rd = (cur_sel < NC) ? cnt[cur_sel] : 0;
                for (int i = 0; i < NC; i++) begin
                    if (((i < N) ? m_stall[i] : m_flush[i-N]) && cnt[i] < SAT) cnt[i]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b1, 4'h0, 16'h0, 3'd0, 1'b0);
        advance();
    endtask

    initial begin
        bit          r, clr;
        logic [3:0]  s;
        logic [15:0] f;
        run  = 0;
        seen = 1'b0;
        rd   = 0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        rst = 1'b1; stall_req = '0; flush_req = '0; perf_sel_i = '0; perf_clr_i = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();
        apply(1'b0, 4'h0, 16'h0, 3'd0, 1'b0);
        check("rst_seen", 32'(wd_seen_o), 32'd0);
        check("rst_perf", 32'(perf_data_o), 32'd0);
        advance();

        // Stall from stage 2 freezes boundaries 0..2.
        apply(1'b0, 4'b0100, 16'h0, 3'd1, 1'b0);
        check("p1_stall", 32'(stall_o), 32'h7);
        check("p1_flush", 32'(flush_o), 32'h0);
        advance();

        // Stage 3 flushing boundary 2 while stalling: flush wins on boundary 2.
        apply(1'b0, 4'b1000, 16'h1 << (3*4 + 2), 3'd2, 1'b0);
        check("p2_flush", 32'(flush_o), 32'h4);
        check("p2_stall", 32'(stall_o), 32'hB);
        advance();

        // Held stall: fires on the 9th and 18th stalled cycles.
        do_reset();
        for (int i = 1; i <= 19; i++) begin
            apply(1'b0, 4'b1000, 16'h0, 3'd4, 1'b0);
            check("p3_fire", 32'(wd_fire_o), 32'(i == 9 || i == 18));
            if (i == 9) begin
                check("p3_fflush", 32'(flush_o), 32'hF);
                check("p3_fstall", 32'(stall_o), 32'h0);
            end
            if (i == 10) check("p3_seen", 32'(wd_seen_o), 32'd1);
            advance();
        end

        // Flush mid-count restarts the watchdog.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            apply(1'b0, 4'b1000, 16'h0, 3'd3, 1'b0);
            advance();
        end
        apply(1'b0, 4'b0000, 16'h0001, 3'd3, 1'b0);
        advance();
        for (int i = 1; i <= 10; i++) begin
            apply(1'b0, 4'b1000, 16'h0, 3'd3, 1'b0);
            check("p4_fire", 32'(wd_fire_o), 32'(i == 9));
            advance();
        end

        // Reset during a stall restarts the count.
        for (int i = 1; i <= 4; i++) begin
            apply(1'b0, 4'b1000, 16'h0, 3'd0, 1'b0);
            advance();
        end
        apply(1'b1, 4'b1000, 16'h0, 3'd0, 1'b0);
        check("p4_rst_fire", 32'(wd_fire_o), 32'd0);
        advance();
        for (int i = 1; i <= 10; i++) begin
            apply(1'b0, 4'b1000, 16'h0, 3'd0, 1'b0);
            if (i == 1) check("p4_rst_seen", 32'(wd_seen_o), 32'd0);
            check("p4_rfire", 32'(wd_fire_o), 32'(i == 9));
            advance();
        end

        // Saturation of counter 0, then clear.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            apply(1'b0, 4'b0001, 16'h0, 3'd0, 1'b0);
            advance();
        end
        apply(1'b0, 4'b0000, 16'h0, 3'd0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        check("p5_sat", 32'(perf_data_o), 32'(SAT));
`else
        check("p5_off", 32'(perf_data_o), 32'd0);
`endif
        advance();
        apply(1'b0, 4'b0000, 16'h0, 3'd0, 1'b1);
        advance();
        apply(1'b0, 4'b0000, 16'h0, 3'd0, 1'b0);
        advance();
        apply(1'b0, 4'b0000, 16'h0, 3'd0, 1'b0);
        check("p5_clr", 32'(perf_data_o), 32'd0);
        advance();

        // Random traffic, stall-heavy so the watchdog gets exercised.
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom % 64) == 0;
            s   = (($urandom % 8) != 0) ? 4'(($urandom % 15) + 1) : 4'h0;
            f   = (($urandom % 16) == 0) ? 16'($urandom) : 16'h0;
            clr = ($urandom % 32) == 0;
            apply(r, s, f, 3'($urandom), clr);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_n.md
# pipe_ctrl_n

Parametrised pipeline hazard controller for the rv5stage core. It generalises the fixed four-boundary stall/flush combiner to `NSTAGES` requesters and boundaries. It adds a stall watchdog that breaks livelocked stalls with a full-pipeline flush, plus optional per-boundary performance counters. It sits beside the datapath, collects every stage's stall/flush requests, and drives the control inputs of the PC and each inter-stage register.

## Interface

**Parameters**
- `NSTAGES`, 4: number of requesting stages and of controlled boundaries. Boundary 0 is the PC; boundary j (j ≥ 1) is the register feeding stage j.
- `STALL_TIMEOUT`, 1024: watchdog limit in consecutive stalled cycles; 0 disables the watchdog.
- `CNT_W`, 32: width of the performance counters.

**Ports**
- `clk` in 1: clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall_req` in NSTAGES: bit k is the stall request from stage k.
- `flush_req` in NSTAGES*NSTAGES: bit k*NSTAGES+j is stage k requesting a flush of boundary j.
- `stall_o` out NSTAGES: per-boundary stall.
- `flush_o` out NSTAGES: per-boundary flush.
- `wd_fire_o` out 1: one-cycle pulse when the watchdog breaks a stall.
- `wd_seen_o` out 1: sticky flag, set by any watchdog fire, cleared only by `rst`.
- `perf_sel_i` in clog2(2*NSTAGES): performance counter select.
- `perf_clr_i` in 1: clear all performance counters.
- `perf_data_o` out CNT_W: selected counter value.

## Operation

**Base combine (combinational, zero latency)**
- `stall_base[j]` = OR of `stall_req[k]` for k ≥ j. A stall freezes its own boundary and every older boundary.
- `flush_o[j]` = OR over k of `flush_req[k*NSTAGES+j]`.
- When both are asserted for the same boundary, flush wins: `stall_o[j]` = `stall_base[j]` & ~`flush_o[j]`.

**Watchdog**
- `wd_cnt` has clog2(STALL_TIMEOUT+1) bits.
- It increments on each cycle where `stall_base[0]` = 1 and no `flush_o` bit is set.
- It clears on any cycle where `stall_base[0]` = 0 or any flush is set.
- Fire condition: `wd_cnt` == STALL_TIMEOUT while `stall_base[0]` is still 1.
- In the fire cycle:
  - all `flush_o` bits are forced to 1;
  - all `stall_o` bits are forced to 0;
  - `wd_fire_o` = 1;
  - `wd_cnt` clears at the next edge;
  - `wd_seen_o` sets at the next edge.
- The core uses `wd_fire_o` to redirect fetch. This block does not supply a PC.
- With STALL_TIMEOUT = 0, `wd_cnt` is held at 0 and the fire condition is never true.

**Reset values**
- `wd_cnt` = 0, `wd_seen_o` = 0, `wd_fire_o` = 0, `perf_data_o` = 0, all counters = 0.
- `stall_o`/`flush_o` stay combinational during reset, but the watchdog cannot fire while `rst` = 1.

## Timing

- `stall_o`, `flush_o` and `wd_fire_o` are valid in the same cycle as their inputs; there is no register on the request path.
- The watchdog fires on the (STALL_TIMEOUT+1)-th consecutive stalled cycle.
- A flush arriving in the same cycle the watchdog would fire takes precedence: the counter clears and `wd_fire_o` stays 0.
- `perf_data_o` is registered with 1-cycle latency from `perf_sel_i`.
- If `perf_clr_i` is asserted, the next read returns 0.
- If the counter is read in the same cycle it increments, the pre-increment value is returned.
- `rst` asserted mid-stall clears `wd_cnt`, so the count restarts from 0 after reset.

## Configuration

**`PIPE_CTRL_PERF_EN`**

- **Defined:** 2*NSTAGES saturating counters of CNT_W bits each.
  - Index j < NSTAGES counts cycles with `stall_o[j]` = 1.
  - Index NSTAGES+j counts cycles with `flush_o[j]` = 1, including watchdog flushes.
  - Counters saturate at all-ones.
  - `perf_clr_i` clears all counters at the next edge; clear wins over a same-cycle increment.
  - A `perf_sel_i` value ≥ 2*NSTAGES reads 0.
- **Undefined:** no counter state is built. `perf_data_o` is constant 0, and `perf_sel_i`/`perf_clr_i` are ignored. The port list is unchanged.

## Test plan

1. NSTAGES=4, `stall_req`=4'b0100 → `stall_o`=4'b0111, `flush_o`=0.
2. `stall_req`=4'b1000 with `flush_req` bit (3*4+2) set → `flush_o`=4'b0100, `stall_o`=4'b1011.
3. STALL_TIMEOUT=8, `stall_req[3]` held high:
   - `wd_fire_o` pulses exactly on the 9th stalled cycle, with `flush_o`=4'b1111 and `stall_o`=0 in that cycle;
   - `wd_seen_o`=1 from the next cycle;
   - while the stall persists, the next pulse comes 9 cycles later.
4. STALL_TIMEOUT=8, stall for 8 cycles, one flush cycle, then stall again → no fire until 9 further stalled cycles; `rst` at stalled cycle 5 → count restarts from 0.
5. PERF_EN, CNT_W=4, `stall_req[0]` held 20 cycles → counter 0 reads 4'hF (saturated). Then `perf_clr_i` → reads 0 one cycle after the following select.
6. PERF_EN off → `perf_data_o`=0 for every `perf_sel_i` under the traffic of scenarios 1–3.
